// File: rtl/lsu_mem_master.sv
// Load/store initiator for the byte-addressed data memory port.
// Aligned requests take one beat; misaligned H/W requests are split into byte beats.
module lsu_mem_master #(
   parameter int MEM_BYTES        = 1024,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   output logic [2:0]  mem_funct3,
   input  logic [31:0] mem_read_data
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  beat_q, beat_d;
   logic [1:0]  last_beat_q, last_beat_d;
   logic        split_q, split_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // Request decode, evaluated on the live request inputs in IDLE.
   logic [32:0] req_size_m1;
   logic [32:0] req_last_addr;
   logic        req_bad_code;
   logic        req_bad_store;
   logic        req_out_of_range;
   logic        req_misaligned;
   logic        req_err;
   logic [1:0]  req_last_beat;

   always_comb begin
      case (req_funct3[1:0])
         2'b01:   req_size_m1 = 33'd1;
         2'b10:   req_size_m1 = 33'd3;
         default: req_size_m1 = 33'd0;
      endcase
   end

   assign req_last_addr    = {1'b0, req_addr} + req_size_m1;
   assign req_bad_code     = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
   assign req_bad_store    = req_we && req_funct3[2];
   assign req_out_of_range = req_last_addr >= 33'(MEM_BYTES);
   assign req_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                             ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign req_err          = req_bad_code || req_bad_store || req_out_of_range ||
                             (req_misaligned && !ALLOW_MISALIGNED);
   assign req_last_beat    = !req_misaligned ? 2'd0 :
                             ((req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3);

   // Buffer with the current beat's byte merged in, so the final beat can complete in one cycle.
   logic [31:0] buf_merged;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_merge
         assign buf_merged[gi*8 +: 8] = (beat_q == 2'(gi)) ? mem_read_data[7:0] : buf_q[gi*8 +: 8];
      end
   endgenerate

   function automatic logic [31:0] extend_split(input logic [2:0] f3, input logic [31:0] b);
      if (f3[1:0] == 2'b01)
         return f3[2] ? {16'h0000, b[15:0]} : {{16{b[15]}}, b[15:0]};
      return b;
   endfunction

   logic        in_access;
   logic [7:0]  split_wbyte;

   assign in_access   = (state_q == ST_ACCESS);
   assign split_wbyte = wdata_q[{beat_q, 3'b000} +: 8];

   assign req_ready      = (state_q == ST_IDLE);
   assign resp_valid     = (state_q == ST_RESP);
   assign resp_rdata     = resp_valid ? rdata_q : 32'h0;
   assign resp_err       = resp_valid && err_q;
   assign mem_addr       = in_access ? (addr_q + {30'd0, beat_q}) : 32'h0;
   assign mem_write      = in_access && we_q;
   assign mem_read       = in_access && !we_q;
   assign mem_funct3     = !in_access ? 3'b000 :
                           (split_q ? (we_q ? 3'b000 : 3'b100) : funct3_q);
   assign mem_write_data = !in_access ? 32'h0 :
                           (split_q ? {24'h0, split_wbyte} : wdata_q);

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      last_beat_d = last_beat_q;
      split_d     = split_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d        = req_we;
               funct3_d    = req_funct3;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               beat_d      = 2'd0;
               last_beat_d = req_last_beat;
               split_d     = req_misaligned;
               buf_d       = 32'h0;
               rdata_d     = 32'h0;
               err_d       = req_err;
               state_d     = req_err ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!we_q && split_q)
               buf_d = buf_merged;
            if (beat_q == last_beat_q) begin
               state_d = ST_RESP;
               if (!we_q)
                  rdata_d = split_q ? extend_split(funct3_q, buf_merged) : mem_read_data;
            end else begin
               beat_d = beat_q + 2'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beat_q      <= 2'd0;
         last_beat_q <= 2'd0;
         split_q     <= 1'b0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         buf_q       <= 32'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         last_beat_q <= last_beat_d;
         split_q     <= split_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests against a byte memory model,
// with separate monitors checking memory beats and responses.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid, req_we, resp_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err, mem_write, mem_read;
   logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
   logic [2:0]  mem_funct3;

   // Second instance with misaligned accesses disabled.
   logic        na_req_valid, na_req_we;
   logic [2:0]  na_req_funct3;
   logic [31:0] na_req_addr;
   logic        na_req_ready, na_resp_valid, na_resp_err, na_mem_write, na_mem_read;
   logic [31:0] na_resp_rdata, na_mem_addr, na_mem_write_data;
   logic [31:0] na_req_wdata     = 32'h0;
   logic [31:0] na_mem_read_data = 32'h0;
   logic        na_resp_ready    = 1'b1;
   logic [2:0]  na_mem_funct3;
   int          na_beats = 0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_mem_master #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write(mem_write),
      .mem_read(mem_read), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
   );

   lsu_mem_master #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
      .clk(clk), .rst(rst),
      .req_valid(na_req_valid), .req_ready(na_req_ready), .req_we(na_req_we),
      .req_funct3(na_req_funct3), .req_addr(na_req_addr), .req_wdata(na_req_wdata),
      .resp_valid(na_resp_valid), .resp_ready(na_resp_ready), .resp_rdata(na_resp_rdata), .resp_err(na_resp_err),
      .mem_addr(na_mem_addr), .mem_write_data(na_mem_write_data), .mem_write(na_mem_write),
      .mem_read(na_mem_read), .mem_funct3(na_mem_funct3), .mem_read_data(na_mem_read_data)
   );

   always @(negedge clk) if (na_mem_read || na_mem_write) na_beats <= na_beats + 1;

   // Byte memory: combinational read with extension, commit on negedge.
   logic [7:0] mem [0:1023];
   logic [9:0] a0, a1, a2, a3;
   assign a0 = mem_addr[9:0];
   assign a1 = a0 + 10'd1;
   assign a2 = a0 + 10'd2;
   assign a3 = a0 + 10'd3;

   always_comb begin
      mem_read_data = 32'h0;
      case (mem_funct3)
         3'b000:  mem_read_data = {{24{mem[a0][7]}}, mem[a0]};
         3'b100:  mem_read_data = {24'h0, mem[a0]};
         3'b001:  mem_read_data = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
         3'b101:  mem_read_data = {16'h0, mem[a1], mem[a0]};
         default: mem_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
      endcase
   end

   always @(negedge clk) begin
      if (mem_write) begin
         case (mem_funct3)
            3'b000: mem[a0] <= mem_write_data[7:0];
            3'b001: begin
               mem[a0] <= mem_write_data[7:0];
               mem[a1] <= mem_write_data[15:8];
            end
            default: begin
               mem[a0] <= mem_write_data[7:0];
               mem[a1] <= mem_write_data[15:8];
               mem[a2] <= mem_write_data[23:16];
               mem[a3] <= mem_write_data[31:24];
            end
         endcase
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
      string       name;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  f3;
      logic        we;
      logic [31:0] wd;
   } beat_t;

   resp_t rq[$];
   beat_t bq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_msg(input string name, input string detail);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, detail);
   endtask

   // Beat and response monitor.
   initial begin
      bit    in_resp = 1'b0;
      int    first_cyc = 0;
      beat_t b;
      resp_t e;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            if (bq.size() == 0) begin
               fail_msg("unexpected_beat", $sformatf("addr 0x%08h we %0d, none required", mem_addr, mem_write));
            end else begin
               b = bq.pop_front();
               chk("beat_addr", mem_addr, b.addr);
               chk("beat_funct3", 32'(mem_funct3), 32'(b.f3));
               chk("beat_we", 32'(mem_write), 32'(b.we));
               if (b.we) chk("beat_wdata", mem_write_data, b.wd);
               $display("beat addr=0x%08h f3=%03b we=%0d wd=0x%08h", mem_addr, mem_funct3, mem_write, mem_write_data);
            end
         end
         if (resp_valid && !in_resp) begin
            in_resp   = 1'b1;
            first_cyc = cyc;
         end
         if (resp_valid && resp_ready) begin
            in_resp = 1'b0;
            if (rq.size() == 0) begin
               fail_msg("unexpected_resp", $sformatf("rdata 0x%08h err %0d, none required", resp_rdata, resp_err));
            end else begin
               e = rq.pop_front();
               chk({e.name, "_rdata"}, resp_rdata, e.rdata);
               chk({e.name, "_err"}, 32'(resp_err), 32'(e.err));
               chk({e.name, "_latency"}, 32'(first_cyc - e.acc), 32'(e.lat));
               $display("resp %s rdata=0x%08h err=%0d latency=%0d", e.name, resp_rdata, resp_err, first_cyc - e.acc);
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int nb, input string name, output int acc);
      int          guard = 0;
      resp_t       e;
      beat_t       b;
      logic [31:0] sh;
      acc = -1;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         fail_msg({name, "_accept"}, "req_ready never rose within 50 cycles");
         return;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      acc        = cyc;
      e.rdata = exp_rd; e.err = exp_err; e.acc = cyc; e.lat = exp_err ? 1 : nb + 1; e.name = name;
      rq.push_back(e);
      if (!exp_err) begin
         for (int k = 0; k < nb; k++) begin
            sh     = wd >> (8 * k);
            b.addr = addr + 32'(k);
            b.f3   = (nb == 1) ? f3 : (we ? 3'b000 : 3'b100);
            b.we   = we;
            b.wd   = (nb == 1) ? wd : {24'h0, sh[7:0]};
            bq.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic wait_idle(input string name);
      int guard = 0;
      @(negedge clk);
      while ((rq.size() != 0 || !req_ready) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (rq.size() != 0 || !req_ready) fail_msg({name, "_drain"}, "responses still pending after 100 cycles");
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
      chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_write_data"}, mem_write_data, 32'h0);
      chk({tag, "_mem_funct3"}, 32'(mem_funct3), 32'd0);
   endtask

   task automatic na_issue(input logic [2:0] f3, input logic [31:0] addr, input logic exp_err,
                           input int exp_beats, input string name);
      int guard = 0;
      int start_beats;
      start_beats = na_beats;
      @(negedge clk);
      na_req_valid  = 1'b1;
      na_req_we     = 1'b0;
      na_req_funct3 = f3;
      na_req_addr   = addr;
      @(posedge clk);
      #1;
      na_req_valid = 1'b0;
      @(negedge clk);
      while (!na_resp_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!na_resp_valid) begin
         fail_msg({name, "_resp"}, "no response within 20 cycles");
      end else begin
         chk({name, "_err"}, 32'(na_resp_err), 32'(exp_err));
         chk({name, "_beats"}, 32'(na_beats - start_beats), 32'(exp_beats));
         $display("na %s err=%0d beats=%0d", name, na_resp_err, na_beats - start_beats);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int acc2;
      int hs;
      int guard;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      resp_ready = 1'b1;
      na_req_valid = 1'b0; na_req_we = 1'b0; na_req_funct3 = 3'b000; na_req_addr = 32'h0;
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h063] <= 8'h5A;
      mem[10'h064] <= 8'hA5;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("reset");

      // Aligned word store/load
      issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1, "st_w_aligned", acc);
      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 1, "ld_w_aligned", acc);

      // Misaligned word split into four byte beats
      issue(1'b1, 3'b010, 32'h41, 32'h11223344, 32'h0, 1'b0, 4, "st_w_split", acc);
      issue(1'b0, 3'b010, 32'h41, 32'h0, 32'h11223344, 1'b0, 4, "ld_w_split", acc);
      wait_idle("split_w");
      chk("mem_41", 32'(mem[10'h041]), 32'h44);
      chk("mem_44", 32'(mem[10'h044]), 32'h11);

      // Misaligned halfword extension
      issue(1'b1, 3'b000, 32'h51, 32'h00000080, 32'h0, 1'b0, 1, "st_b_51", acc);
      issue(1'b1, 3'b000, 32'h52, 32'h0000007F, 32'h0, 1'b0, 1, "st_b_52", acc);
      issue(1'b0, 3'b001, 32'h51, 32'h0, 32'h00007F80, 1'b0, 2, "ld_h_split_pos", acc);
      issue(1'b1, 3'b000, 32'h52, 32'h000000FF, 32'h0, 1'b0, 1, "st_b_52_ff", acc);
      issue(1'b0, 3'b001, 32'h51, 32'h0, 32'hFFFFFF80, 1'b0, 2, "ld_h_split_neg", acc);
      issue(1'b0, 3'b101, 32'h51, 32'h0, 32'h0000FF80, 1'b0, 2, "ld_hu_split", acc);
      issue(1'b0, 3'b000, 32'h51, 32'h0, 32'hFFFFFF80, 1'b0, 1, "ld_b_51", acc);

      // Aligned halfword passes its width code straight to memory
      issue(1'b1, 3'b001, 32'h30, 32'h1234ABCD, 32'h0, 1'b0, 1, "st_h_aligned", acc);
      issue(1'b0, 3'b101, 32'h30, 32'h0, 32'h0000ABCD, 1'b0, 1, "ld_hu_aligned", acc);
      issue(1'b0, 3'b001, 32'h30, 32'h0, 32'hFFFFABCD, 1'b0, 1, "ld_h_aligned", acc);

      // Error paths and range boundaries
      issue(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 0, "ld_bad_f3", acc);
      issue(1'b1, 3'b010, 32'd1022, 32'h12345678, 32'h0, 1'b1, 0, "st_w_range", acc);
      issue(1'b1, 3'b100, 32'h20, 32'h00000055, 32'h0, 1'b1, 0, "st_bu_bad", acc);
      issue(1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 1'b1, 0, "ld_h_3ff", acc);
      issue(1'b0, 3'b000, 32'h3FF, 32'h0, 32'h0, 1'b0, 1, "ld_b_3ff", acc);
      issue(1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0, 1'b0, 1, "ld_w_3fc", acc);
      wait_idle("errors");
      chk("mem_1022", 32'(mem[10'd1022]), 32'h0);
      chk("mem_1023", 32'(mem[10'd1023]), 32'h0);
      chk("mem_20", 32'(mem[10'h020]), 32'hEF);

      // Backpressure: response held, competing request ignored until after handshake
      resp_ready = 1'b0;
      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 1, "ld_bp", acc);
      guard = 0;
      @(negedge clk);
      while (!resp_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h41; req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", 32'(resp_valid), 32'd1);
         chk("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
      hs = cyc;
      chk("bp_req_ready_at_hs", 32'(req_ready), 32'd0);
      issue(1'b0, 3'b010, 32'h41, 32'h0, 32'h11223344, 1'b0, 4, "ld_after_bp", acc2);
      chk("bp_accept_delay", 32'(acc2 - hs), 32'd1);
      wait_idle("bp");

      // Reset during the second beat of a split store: two bytes land, the rest untouched
      issue(1'b1, 3'b010, 32'h61, 32'hAABBCCDD, 32'h0, 1'b0, 2, "st_w_reset", acc);
      void'(rq.pop_back());
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("mid_reset");
      chk("rst_mem_61", 32'(mem[10'h061]), 32'hDD);
      chk("rst_mem_62", 32'(mem[10'h062]), 32'hCC);
      chk("rst_mem_63", 32'(mem[10'h063]), 32'h5A);
      chk("rst_mem_64", 32'(mem[10'h064]), 32'hA5);
      issue(1'b0, 3'b000, 32'h62, 32'h0, 32'hFFFFFFCC, 1'b0, 1, "ld_after_reset", acc);
      wait_idle("after_reset");

      // Misaligned rejected when splitting is disabled
      na_issue(3'b001, 32'h03, 1'b1, 0, "na_h_misaligned");
      na_issue(3'b001, 32'h02, 1'b0, 1, "na_h_aligned");

      repeat (3) @(negedge clk);
      chk("beat_queue_empty", 32'(bq.size()), 32'd0);
      chk("resp_queue_empty", 32'(rq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Core-side initiator for the byte-addressed data memory port. It accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Aligned accesses are issued to the memory as a single beat.
- Misaligned halfword/word accesses are split into sequential byte beats. Load bytes are reassembled and sign/zero-extended.
- Returns the load data, or an error flag, over a valid/ready response channel.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; any request touching byte address >= MEM_BYTES is an error.
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into byte beats; 0 = misaligned access is an error.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes are used.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; no memory write occurred.
- mem_addr  out  32  memory byte address.
- mem_write_data  out  32  memory write data.
- mem_write  out  1  memory write strobe; memory commits on negedge clk.
- mem_read  out  1  memory read enable.
- mem_funct3  out  3  width code presented to memory.
- mem_read_data  in  32  combinational read data from memory.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset: state=IDLE, beat counter=0, data buffer=0. Outputs after reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_read=0, mem_addr=0, mem_write_data=0, mem_funct3=0.
- All mem_* outputs are 0 outside ACCESS.

Request acceptance (IDLE, req_valid=1):
- The request is latched.
- Error conditions:
  - funct3 is 011, 110 or 111;
  - store with funct3 100 or 101;
  - last byte address (addr + size - 1) >= MEM_BYTES;
  - misaligned access while ALLOW_MISALIGNED=0.
- Error path: go to RESP with resp_err=1 and issue no memory beat.
- Otherwise go to ACCESS with beat=0.
- Number of beats:
  - 1 when aligned (H: addr[0]=0; W: addr[1:0]=0; B/BU always aligned).
  - Otherwise 2 for H/HU and 4 for W.

ACCESS, aligned beat:
- mem_addr = addr, mem_funct3 = req funct3, mem_write_data = wdata.
- mem_read = !we, mem_write = we.
- For a load, resp_rdata is captured from mem_read_data at the posedge.

ACCESS, split beat k (k = 0..N-1):
- mem_addr = addr + k.
- Load: mem_funct3 = 100 and mem_read = 1; mem_read_data[7:0] is captured into buffer byte k.
- Store: mem_funct3 = 000, mem_write = 1, mem_write_data[7:0] = wdata byte k.
- Address addition is 32-bit; wrap cannot occur because the range check rejects it first.

Completion:
- After the last beat, go to RESP.
- Split-load result: buffer[15:0] or buffer[31:0], sign-extended for H and zero-extended for HU.

Latency:
- Request accepted at cycle N; beats occupy N+1 .. N+beats; resp_valid rises at N+beats+1.
- Error responses rise at N+1.

RESP:
- resp_valid=1; resp_rdata and resp_err are stable.
- resp_valid=1 and resp_ready=1 -> IDLE.
- No new request is accepted in the same cycle; req_ready rises the following cycle.

Reset mid-operation:
- Return to IDLE immediately at that edge; mem_write is deasserted.
- Byte beats of a split store already committed stay written; there is no rollback.

Other rules:
- Request inputs are ignored whenever req_ready=0.
- req_* changes after acceptance do not affect the in-flight access.

Test Plan:
1. Aligned word store/load: store addr 0x20, funct3 010, wdata 0xDEADBEEF, then load addr 0x20, funct3 010 -> each takes one beat; load resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid 2 cycles after acceptance.
2. Misaligned word split: store 0x11223344 at addr 0x41, then load W at 0x41 -> four byte beats with mem_addr 0x41..0x44 and mem_funct3 000 (store) / 100 (load); rdata = 0x11223344; resp_valid 5 cycles after acceptance.
3. Misaligned halfword extension: store byte 0x80 at 0x51 and byte 0x7F at 0x52; load H at 0x51 -> 0xFFFF7F80? No: bytes assemble as {0x7F,0x80}, so H -> 0x00007F80; storing 0xFF at 0x52 instead gives H -> 0xFFFFFF80 and HU -> 0x0000FF80.
4. Errors: load funct3 011 -> resp_err = 1 one cycle after acceptance, no mem_read/mem_write pulse. Store W at addr 1022 (MEM_BYTES = 1024) -> resp_err = 1 and memory unchanged. ALLOW_MISALIGNED = 0 with H at 0x03 -> resp_err = 1.
5. Backpressure: hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready = 0, a second request is not accepted until one cycle after the handshake.
6. Reset mid-store: split W store of 0xAABBCCDD at 0x61 with rst asserted during beat 2 -> bytes 0x61 and 0x62 = 0xDD and 0xCC, 0x63 and 0x64 unchanged; next cycle is IDLE with all outputs at reset values.
